// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the program counter, presents it to the
// instruction memory on PC_Out and samples the combinational Instr that comes
// back in the same cycle. The fetched word is registered into the IF/ID
// pipeline register. Stalls, flushes and branch/jump redirects from later
// stages are handled here. Fetch stops permanently (until reset) on an
// out-of-range or misaligned PC.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds the Fetch_Count and Bubble_Count performance counters.
//
// Ports:
//   CLK           in   1   system clock, rising edge
//   RST_N         in   1   asynchronous active-low reset
//   Stall_F       in   1   hold PC and IF/ID contents
//   Flush_D       in   1   replace IF/ID contents with a bubble
//   Branch_Taken  in   1   redirect request from execute
//   Branch_Target in  32   redirect address
//   Instr         in  32   instruction memory word for PC_Out (same cycle)
//   PC_Out        out 32   fetch address to instruction memory
//   Instr_D       out 32   IF/ID instruction
//   PC_D          out 32   IF/ID PC of Instr_D
//   PC_Plus4_D    out 32   PC_D + 4
//   Valid_D       out  1   Instr_D is a real instruction
//   Fetch_Fault   out  1   sticky fault flag
//   Fetch_Count   out 32   (FETCH_PERF_CNT_EN) valid IF/ID loads
//   Bubble_Count  out 32   (FETCH_PERF_CNT_EN) bubble IF/ID loads
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH   = 256,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Stall_F,
    input  logic        Flush_D,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic [31:0] Instr,
    output logic [31:0] PC_Out,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC_Plus4_D,
    output logic        Valid_D,
    output logic        Fetch_Fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_Count,
    output logic [31:0] Bubble_Count
`endif
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_q,       state_d;
    logic [31:0] pc_out_q,      pc_out_d;
    logic [31:0] ifid_instr_q,  ifid_instr_d;
    logic [31:0] ifid_pc_q,     ifid_pc_d;
    logic [31:0] ifid_pc4_q,    ifid_pc4_d;
    logic        ifid_valid_q,  ifid_valid_d;
    logic        fault_q,       fault_d;

    logic [31:0] pc_plus4_s;
    logic        pc_fault_s;
    logic        load_fetch_s;
    logic        load_bubble_s;

    assign pc_plus4_s = pc_out_q + 32'd4;

    // The word index is widened to 32 bits so an IMEM_DEPTH of 2^30 or more
    // still compares correctly.
    assign pc_fault_s = (pc_out_q[1:0] != 2'b00) ||
                        ({2'b00, pc_out_q[31:2]} >= 32'(IMEM_DEPTH));

    // Next-state logic: fault > redirect > stall > flush > sequential fetch.
    always_comb begin
        state_d       = state_q;
        pc_out_d      = pc_out_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pc4_d    = ifid_pc4_q;
        ifid_valid_d  = ifid_valid_q;
        fault_d       = fault_q;
        load_fetch_s  = 1'b0;
        load_bubble_s = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Single settling cycle; all control inputs are ignored.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (pc_fault_s) begin
                    // The word at a bad PC is never registered.
                    state_d       = ST_HALT;
                    fault_d       = 1'b1;
                    load_bubble_s = 1'b1;
                end else if (Branch_Taken) begin
                    // Target loaded unchanged; a bad target faults next edge.
                    pc_out_d      = Branch_Target;
                    load_bubble_s = 1'b1;
                end else if (Stall_F) begin
                    if (Flush_D) begin
                        load_bubble_s = 1'b1;
                    end else begin
                        load_bubble_s = 1'b0;
                    end
                end else if (Flush_D) begin
                    pc_out_d      = pc_plus4_s;
                    load_bubble_s = 1'b1;
                end else begin
                    pc_out_d      = pc_plus4_s;
                    load_fetch_s  = 1'b1;
                end
            end
            ST_HALT: begin
                fault_d       = 1'b1;
                load_bubble_s = 1'b1;
            end
            default: begin
                // Corrupted state encoding is treated as a fault.
                state_d       = ST_HALT;
                fault_d       = 1'b1;
                load_bubble_s = 1'b1;
            end
        endcase

        if (load_fetch_s) begin
            ifid_instr_d = Instr;
            ifid_pc_d    = pc_out_q;
            ifid_pc4_d   = pc_plus4_s;
            ifid_valid_d = 1'b1;
        end else if (load_bubble_s) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc_d    = 32'd0;
            ifid_pc4_d   = 32'd0;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_instr_d = ifid_instr_q;
        end
    end

    // State, PC and IF/ID pipeline register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_BOOT;
            pc_out_q     <= RESET_VECTOR;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_out_q     <= pc_out_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign PC_Out      = pc_out_q;
    assign Instr_D     = ifid_instr_q;
    assign PC_D        = ifid_pc_q;
    assign PC_Plus4_D  = ifid_pc4_q;
    assign Valid_D     = ifid_valid_q;
    assign Fetch_Fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Free-running counters of valid and bubble IF/ID loads; stalls count as neither.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (load_fetch_s) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (load_bubble_s) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign Fetch_Count  = fetch_cnt_q;
    assign Bubble_Count = bubble_cnt_q;
`endif

endmodule
